// File: rtl/axil_heartbeat_monitor.sv
// AXI4-Lite heartbeat sink: records watchdog heartbeats, counts misses.
// Optional irq output and STATUS.irq_en with HEARTBEAT_MONITOR_IRQ_EN.
module axil_heartbeat_monitor #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 28,
  parameter int TIMEOUT_CYCLES     = 50000000
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic [2:0]                      s_axil_awprot,
  input  logic                            s_axil_awvalid,
  output logic                            s_axil_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axil_wstrb,
  input  logic                            s_axil_wvalid,
  output logic                            s_axil_wready,
  output logic [1:0]                      s_axil_bresp,
  output logic                            s_axil_bvalid,
  input  logic                            s_axil_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic [2:0]                      s_axil_arprot,
  input  logic                            s_axil_arvalid,
  output logic                            s_axil_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]                      s_axil_rresp,
  output logic                            s_axil_rvalid,
  input  logic                            s_axil_rready,
  output logic                            timeout
`ifdef HEARTBEAT_MONITOR_IRQ_EN
  ,
  output logic                            irq
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam int DW = C_S_AXI_DATA_WIDTH;

  typedef enum logic { W_IDLE, W_RESP } w_state_e;
  typedef enum logic { R_IDLE, R_DATA } r_state_e;

  w_state_e        w_state_q;
  r_state_e        r_state_q;
  logic            awready_q;
  logic            bvalid_q;
  logic            arready_q;
  logic            rvalid_q;
  logic [DW-1:0]   rdata_q;

  logic [DW-1:0]   hb_q, hb_d;
  logic [31:0]     count_q, count_d;
  logic [31:0]     misses_q, misses_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            armed_q, armed_d;
  logic            timeout_q, timeout_d;
  logic            irq_en_q, irq_en_d;

  logic            wr_fire;
  logic            rd_fire;
  logic            hb_wr;
  logic            st_wr;
  logic            expire;
  logic [DW-1:0]   rd_mux;

  logic            unused_ok;

  assign unused_ok = ^{s_axil_awprot, s_axil_arprot, s_axil_wstrb,
                       s_axil_awaddr[C_S_AXI_ADDR_WIDTH-1:4],
                       s_axil_awaddr[1:0],
                       s_axil_araddr[C_S_AXI_ADDR_WIDTH-1:4],
                       s_axil_araddr[1:0]};

  assign wr_fire = (w_state_q == W_IDLE) & awready_q
                 & s_axil_awvalid & s_axil_wvalid;
  assign rd_fire = (r_state_q == R_IDLE) & arready_q & s_axil_arvalid;
  assign hb_wr   = wr_fire & (s_axil_awaddr[3:2] == 2'd0);
  assign st_wr   = wr_fire & (s_axil_awaddr[3:2] == 2'd2);

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = awready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = 2'b00;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = 2'b00;
  assign timeout        = timeout_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      unique case (w_state_q)
        W_IDLE: begin
          if (wr_fire) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b1;
            w_state_q <= W_RESP;
          end else begin
            awready_q <= s_axil_awvalid & s_axil_wvalid & ~awready_q;
          end
        end
        W_RESP: begin
          if (s_axil_bready) begin
            bvalid_q  <= 1'b0;
            w_state_q <= W_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      unique case (r_state_q)
        R_IDLE: begin
          if (rd_fire) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_mux;
            r_state_q <= R_DATA;
          end else begin
            arready_q <= s_axil_arvalid & ~arready_q;
          end
        end
        R_DATA: begin
          if (s_axil_rready) begin
            rvalid_q  <= 1'b0;
            r_state_q <= R_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (s_axil_araddr[3:2])
      2'd0: rd_mux = hb_q;
      2'd1: rd_mux = DW'(count_q);
      2'd2: begin
        rd_mux[0] = timeout_q;
        rd_mux[1] = armed_q;
        rd_mux[2] = irq_en_q;
      end
      2'd3: rd_mux = DW'(misses_q);
    endcase
  end

  // A heartbeat in the expiry cycle wins; a W1C loses to a new expiry.
  always_comb begin
    hb_d      = hb_q;
    count_d   = count_q;
    misses_d  = misses_q;
    timer_d   = timer_q;
    armed_d   = armed_q;
    timeout_d = timeout_q;
    irq_en_d  = irq_en_q;
    expire    = 1'b0;
    if (hb_wr) begin
      hb_d    = s_axil_wdata;
      count_d = count_q + 32'd1;
      armed_d = 1'b1;
      timer_d = '0;
    end else if (armed_q) begin
      if (timer_q == T_LAST) begin
        expire  = 1'b1;
        timer_d = '0;
        if (misses_q != 32'hFFFF_FFFF) begin
          misses_d = misses_q + 32'd1;
        end
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
    if (st_wr && s_axil_wdata[0]) begin
      timeout_d = 1'b0;
    end
    if (expire) begin
      timeout_d = 1'b1;
    end
`ifdef HEARTBEAT_MONITOR_IRQ_EN
    if (st_wr) begin
      irq_en_d = s_axil_wdata[2];
    end
`endif
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      hb_q      <= '0;
      count_q   <= '0;
      misses_q  <= '0;
      timer_q   <= '0;
      armed_q   <= 1'b0;
      timeout_q <= 1'b0;
      irq_en_q  <= 1'b0;
    end else begin
      hb_q      <= hb_d;
      count_q   <= count_d;
      misses_q  <= misses_d;
      timer_q   <= timer_d;
      armed_q   <= armed_d;
      timeout_q <= timeout_d;
      irq_en_q  <= irq_en_d;
    end
  end

`ifdef HEARTBEAT_MONITOR_IRQ_EN
  logic irq_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= timeout_d & irq_en_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_axil_heartbeat_monitor.sv
// Randomized bench for axil_heartbeat_monitor against an event-time model.
// Covers the irq port when HEARTBEAT_MONITOR_IRQ_EN is defined.
module tb_axil_heartbeat_monitor;

  localparam int TO = 100;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [27:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = 4'hF;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [27:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        timeout;
`ifdef HEARTBEAT_MONITOR_IRQ_EN
  logic        irq;
`endif

  always #5 aclk = ~aclk;

  axil_heartbeat_monitor #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(28),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .s_axil_awaddr(awaddr),
    .s_axil_awprot(awprot),
    .s_axil_awvalid(awvalid),
    .s_axil_awready(awready),
    .s_axil_wdata(wdata),
    .s_axil_wstrb(wstrb),
    .s_axil_wvalid(wvalid),
    .s_axil_wready(wready),
    .s_axil_bresp(bresp),
    .s_axil_bvalid(bvalid),
    .s_axil_bready(bready),
    .s_axil_araddr(araddr),
    .s_axil_arprot(arprot),
    .s_axil_arvalid(arvalid),
    .s_axil_arready(arready),
    .s_axil_rdata(rdata),
    .s_axil_rresp(rresp),
    .s_axil_rvalid(rvalid),
    .s_axil_rready(rready),
    .timeout(timeout)
`ifdef HEARTBEAT_MONITOR_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: heartbeats and clears are kept as edge numbers; expiries
  // and misses are derived from elapsed time arithmetic.
  longint      cyc = 0;
  longint      ar_edge = 0;
  bit          m_armed;
  longint      m_last;
  longint      m_last_exp;
  longint      m_clear;
  longint      m_base;
  logic [31:0] m_hb;
  logic [31:0] m_count;
  bit          m_irq_en;
  bit          chk_on = 1'b0;

  function automatic void model_reset();
    m_armed    = 1'b0;
    m_last     = 0;
    m_last_exp = -1;
    m_clear    = 0;
    m_base     = 0;
    m_hb       = '0;
    m_count    = '0;
    m_irq_en   = 1'b0;
  endfunction

  function automatic longint exp_latest(longint n);
    if (m_armed && (n - m_last) >= TO)
      return m_last + TO * ((n - m_last) / TO);
    return m_last_exp;
  endfunction

  function automatic logic [31:0] misses_at(longint n);
    longint m;
    m = m_base;
    if (m_armed && n > m_last) m = m + (n - m_last) / TO;
    if (m > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
    return m[31:0];
  endfunction

  function automatic bit timeout_at(longint n);
    return exp_latest(n) >= m_clear;
  endfunction

  function automatic logic [31:0] reg_at(int idx, longint n);
    logic [31:0] v;
    v = '0;
    case (idx)
      0: v = m_hb;
      1: v = m_count;
      2: begin
        v[0] = timeout_at(n);
        v[1] = m_armed;
`ifdef HEARTBEAT_MONITOR_IRQ_EN
        v[2] = m_irq_en;
`endif
      end
      default: v = misses_at(n);
    endcase
    return v;
  endfunction

  function automatic void model_write(longint c, logic [1:0] a, logic [31:0] d);
    longint k;
    if (a == 2'd0) begin
      if (m_armed) begin
        k = (c - 1 - m_last) / TO;
        if (k > 0) begin
          m_base     = m_base + k;
          m_last_exp = m_last + TO * k;
        end
      end
      m_last  = c;
      m_armed = 1'b1;
      m_count = m_count + 32'd1;
      m_hb    = d;
    end else if (a == 2'd2) begin
      if (d[0]) m_clear = c;
`ifdef HEARTBEAT_MONITOR_IRQ_EN
      m_irq_en = d[2];
`endif
    end
  endfunction

  initial model_reset();

  always @(posedge aclk) begin
    cyc = cyc + 1;
    if (!aresetn) begin
      model_reset();
    end else begin
      if (awready && awvalid && wvalid)
        model_write(cyc, awaddr[3:2], wdata);
      if (arready && arvalid)
        ar_edge = cyc;
    end
  end

  always @(negedge aclk) begin
    if (chk_on) begin
      check("timeout_pin", timeout, timeout_at(cyc));
`ifdef HEARTBEAT_MONITOR_IRQ_EN
      check("irq_pin", irq, timeout_at(cyc) & m_irq_en);
`endif
    end
  end

  function automatic logic [27:0] alias_addr(int idx);
    logic [27:0] a;
    a = 28'($urandom_range(0, 32'h00FF_FFFF)) << 4;
    a[3:2] = idx[1:0];
    return a;
  endfunction

  task automatic axi_write(int idx, logic [31:0] data, int bdelay);
    int k;
    k = 0;
    @(negedge aclk);
    awaddr  = alias_addr(idx);
    wdata   = data;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    do begin
      @(posedge aclk);
      k++;
    end while (!awready && k < 20);
    check("aw_latency", k, 2);
    @(negedge aclk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("bvalid_rise", bvalid, 1);
    check("bresp", bresp, 0);
    repeat (bdelay) begin
      @(negedge aclk);
      check("bvalid_hold", bvalid, 1);
    end
    bready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    bready = 1'b0;
    check("bvalid_fall", bvalid, 0);
  endtask

  task automatic axi_read(int idx, output logic [31:0] data);
    int k;
    k = 0;
    @(negedge aclk);
    araddr  = alias_addr(idx);
    arvalid = 1'b1;
    do begin
      @(posedge aclk);
      k++;
    end while (!arready && k < 20);
    check("ar_latency", k, 2);
    @(negedge aclk);
    arvalid = 1'b0;
    check("rvalid_rise", rvalid, 1);
    check("rresp", rresp, 0);
    data   = rdata;
    rready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    rready = 1'b0;
    check("rvalid_fall", rvalid, 0);
  endtask

  task automatic read_check(string tag, int idx);
    logic [31:0] d;
    axi_read(idx, d);
    check(tag, d, reg_at(idx, ar_edge - 1));
  endtask

  task automatic read_const(string tag, int idx, logic [31:0] exp);
    logic [31:0] d;
    axi_read(idx, d);
    check(tag, d, exp);
  endtask

  task automatic wait_until(longint e);
    while (cyc < e) @(negedge aclk);
  endtask

  function automatic longint next_exp();
    longint e;
    e = m_last + TO * ((cyc - m_last) / TO + 1);
    if (e - 3 < cyc) e = e + TO;
    return e;
  endfunction

  initial begin
    longint e;
    int     k;
    aresetn = 1'b0;
    repeat (4) @(negedge aclk);
    aresetn = 1'b1;
    chk_on  = 1'b1;
    check("reset_timeout", timeout, 0);
    check("reset_bvalid", bvalid, 0);
    check("reset_rvalid", rvalid, 0);
    check("reset_rdata", rdata, 0);
    for (int i = 0; i < 4; i++) read_const("reset_reg", i, 0);

    for (int i = 0; i < 3; i++) axi_write(0, 32'hCAFE_0001, i);
    read_const("count3", 1, 3);
    read_const("hb_val", 0, 32'hCAFE_0001);
    read_const("status_armed", 2, 32'h2);

    wait_until(m_last + TO - 1);
    check("timeout_pre", timeout, 0);
    wait_until(m_last + TO);
    check("timeout_set", timeout, 1);
    read_const("misses1", 3, 1);
    wait_until(m_last + 2 * TO);
    read_const("misses2", 3, 2);

    axi_write(2, 32'h1, 0);
    read_const("status_w1c", 2, 32'h2);

    e = next_exp();
    wait_until(e - 3);
    axi_write(0, 32'h0000_1234, 0);
    read_const("hb_on_expiry_misses", 3, 2);
    read_const("hb_on_expiry_status", 2, 32'h2);
    check("hb_on_expiry_timeout", timeout, 0);

    wait_until(m_last + TO);
    read_const("status_to", 2, 32'h3);
    axi_write(2, 32'h1, 0);
    read_const("status_clr", 2, 32'h2);
    e = next_exp();
    wait_until(e - 3);
    axi_write(2, 32'h1, 0);
    read_const("w1c_vs_expiry", 2, 32'h3);

    // Stalled B channel with a second write pending behind it.
    @(negedge aclk);
    awaddr = alias_addr(1);
    wdata = 32'hDEAD_0000;
    awvalid = 1'b1;
    wvalid = 1'b1;
    k = 0;
    do begin
      @(posedge aclk);
      k++;
    end while (!awready && k < 20);
    check("stall_aw_latency", k, 2);
    @(negedge aclk);
    awaddr = alias_addr(0);
    wdata = 32'hBEEF_0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      check("stall_bvalid", bvalid, 1);
      check("stall_awready", awready, 0);
    end
    awvalid = 1'b0;
    wvalid = 1'b0;
    bready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    bready = 1'b0;
    read_const("stall_hb", 0, 32'h0000_1234);
    read_const("stall_count", 1, 4);

`ifdef HEARTBEAT_MONITOR_IRQ_EN
    axi_write(2, 32'h4, 0);
    check("irq_on", irq, 1);
    read_const("status_irq", 2, 32'h7);
`endif

    for (int n = 0; n < 80; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        axi_write(0, $urandom, $urandom_range(0, 3));
      end else if (r == 3) begin
        axi_write($urandom_range(1, 3), $urandom, $urandom_range(0, 2));
      end else if (r <= 6) begin
        read_check("rand_read", $urandom_range(0, 3));
      end else if (r <= 8) begin
        repeat ($urandom_range(1, 150)) @(negedge aclk);
      end else if (m_armed) begin
        e = next_exp() + longint'($urandom_range(0, 2)) - 1;
        wait_until(e - 3);
        axi_write($urandom_range(0, 1) == 0 ? 0 : 2, $urandom, 0);
      end
      if (n % 10 == 9) begin
        for (int i = 0; i < 4; i++) read_check("rand_sweep", i);
      end
    end

    // Reset while a write response is still outstanding.
    @(negedge aclk);
    awaddr = alias_addr(0);
    wdata = 32'h5555_AAAA;
    awvalid = 1'b1;
    wvalid = 1'b1;
    k = 0;
    do begin
      @(posedge aclk);
      k++;
    end while (!awready && k < 20);
    @(negedge aclk);
    awvalid = 1'b0;
    wvalid = 1'b0;
    check("pre_rst_bvalid", bvalid, 1);
    aresetn = 1'b0;
    @(negedge aclk);
    check("rst_bvalid", bvalid, 0);
    check("rst_awready", awready, 0);
    check("rst_timeout", timeout, 0);
    aresetn = 1'b1;
    for (int i = 0; i < 4; i++) read_const("post_rst_reg", i, 0);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
